// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage and a synchronous-read IMEM.
// rdata answers the request issued in the previous cycle.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output rdata
    );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, IMEM request, 1-entry skid and IF/ID register.
// A response arriving while decode is stalled parks in the skid until release.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    if_stage_if.master        imem,
    output logic              ifid_valid_o,
    output logic [31:0]       ifid_pc_o,
    output logic [31:0]       ifid_pc4_o,
    output logic [31:0]       ifid_instr_o,
    output logic              misalign_o
);

    logic        fetch_req;

    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        misalign_q, misalign_d;

    assign fetch_req = !rst && !stall_i && !redirect_i;

    always_comb begin
        pc_d         = pc_q;
        pend_valid_d = fetch_req;
        pend_pc_d    = pend_pc_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        misalign_d   = misalign_q;

        if (fetch_req) begin
            pend_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
        end

        // Highest priority first: a redirect discards everything in flight.
        if (redirect_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            pend_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = {redirect_pc_i[31:2], 2'b00};
            if (redirect_pc_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (stall_i) begin
            if (pend_valid_q && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = pend_pc_q;
                skid_instr_d = imem.rdata;
            end
        end else if (skid_valid_q) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc_q;
            ifid_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pend_pc_q;
            ifid_instr_d = imem.rdata;
        end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            misalign_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem.req     = fetch_req;
    assign imem.addr    = pc_q;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc_q + 32'd4;
    assign ifid_instr_o = ifid_instr_q;
    assign misalign_o   = misalign_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the RV32I 5-stage pipeline: owns the PC, issues word fetches to a synchronous-read IMEM, and produces the IF/ID pipeline register consumed by decode.
- Accepts load-use stall from the hazard unit and taken-branch/jump redirect from EX.
- A 1-entry skid buffer captures IMEM read data that returns during a stall, so no instruction is lost or duplicated.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) driven on ifid_instr_o when IF/ID holds a bubble

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall_i  in  1  hold PC and IF/ID (load-use hazard)
redirect_i  in  1  taken branch/jump resolved in EX; flush IF and IF/ID
redirect_pc_i  in  32  redirect target byte address
imem_req_o  out  1  fetch request this cycle
imem_addr_o  out  32  word-aligned fetch byte address (bits[1:0]=0)
imem_rdata_i  in  32  instruction for the request issued in the previous cycle; valid only that one cycle
ifid_valid_o  out  1  IF/ID holds a real instruction
ifid_pc_o  out  32  PC of IF/ID instruction
ifid_pc4_o  out  32  ifid_pc_o + 4 (mod 2^32)
ifid_instr_o  out  32  IF/ID instruction, NOP_INSTR when invalid
misalign_o  out  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset:
  - pc_q=RESET_PC; pend_valid=0, skid_valid=0.
  - ifid_valid_o=0, ifid_pc_o=0, ifid_pc4_o=4, ifid_instr_o=NOP_INSTR, misalign_o=0, imem_req_o=0.
  - rst overrides stall_i and redirect_i.
- Request:
  - imem_req_o = !rst && !stall_i && !redirect_i; imem_addr_o = pc_q.
  - On a request: pend_valid<=1, pend_pc<=pc_q, pc_q<=pc_q+4 (wraps 0xFFFF_FFFC -> 0).
  - With no request, pend_valid<=0 after any capture below.
- Response: in the cycle with pend_valid=1, imem_rdata_i is the instruction at pend_pc.
- IF/ID update, priority order:
  1. redirect_i: ifid_valid<=0, instr<=NOP_INSTR; pend_valid<=0 and skid_valid<=0 (in-flight fetch discarded); pc_q<={redirect_pc_i[31:2],2'b00}; if redirect_pc_i[1:0]!=0 then misalign_o<=1 (sticky until rst).
  2. stall_i: IF/ID holds. If pend_valid && !skid_valid, the skid captures {pend_pc, imem_rdata_i}. pc_q holds.
  3. skid_valid: IF/ID<=skid, skid_valid<=0. A new request issues the same cycle.
  4. pend_valid: IF/ID<={pend_pc, imem_rdata_i}, valid=1.
  5. Otherwise: ifid_valid<=0, instr<=NOP_INSTR.
- Invariant: at most one pending response plus one skid entry, so pend_valid and skid_valid both set never requires a third slot. A request is never issued while stalled.
- Latency:
  - First cycle with rst=0 is cycle 0: request RESET_PC in cycle 0, IF/ID valid with RESET_PC from cycle 2.
  - Redirect asserted in cycle r: bubble in IF/ID at r+1 and r+2; target request in r+1; target visible in IF/ID at r+3.
- Steady state: one instruction per cycle, PCs strictly sequential between redirects.
- ifid_pc4_o is combinational from the registered ifid_pc_o.

Test Plan:
- Reset release, IMEM model returns {addr} as data, no stall -> ifid_valid_o rises at cycle 2; ifid_pc_o/ifid_instr_o = 0x0,0x4,0x8,... one per cycle; ifid_pc4_o = pc+4.
- stall_i high 3 cycles while IF/ID=0x8 and 0xC pending -> imem_req_o=0 for 3 cycles, IF/ID holds 0x8; after release IF/ID = 0xC, 0x10, 0x14 with no gap, loss or duplicate.
- redirect_i with redirect_pc_i=0x40 while 0x10 in flight -> 0x10 never appears; ifid_valid_o=0 for 2 cycles (instr=0x00000013); then 0x40, 0x44.
- redirect_i and stall_i asserted together, target 0x80 -> redirect wins; skid cleared; next valid IF/ID pc=0x80.
- redirect_pc_i=0x42 -> misalign_o=1 and stays 1; fetch resumes at 0x40; rst clears misalign_o.
- RESET_PC=0xFFFF_FFF8 -> IF/ID pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; ifid_pc4_o for 0xFFFFFFFC = 0x00000000.
